// File: rtl/regfile.sv
// Two-read, one-write register file with a single-entry write-back latch.
// Write-back data is captured into the latch on one edge and committed to
// the array on the next. Read ports are combinational and bypass only the
// latched (pending) write, never the raw i_wb_* inputs.
module regfile #(
   parameter int N_REG      = 32,
   parameter int N_REG_ADDR = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wb_wen,
   input  logic [N_REG_ADDR-1:0] i_wb_waddr,
   input  logic [N_REG-1:0]      i_wb_wdata,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [N_REG_ADDR-1:0] i_reg_0_addr,
   input  logic                  i_reg_0_ren,
   input  logic [N_REG_ADDR-1:0] i_reg_1_addr,
   input  logic                  i_reg_1_ren,
   output logic [N_REG-1:0]      o_reg_0_data,
   output logic [N_REG-1:0]      o_reg_1_data,
   output logic                  o_wb_busy
);

   localparam int N_ENTRY = 2 ** N_REG_ADDR;
   localparam int N_PORT  = 2;

   // Write-back latch (one pending write)
   logic                  wb_wen_reg,   wb_wen_next;
   logic [N_REG_ADDR-1:0] wb_waddr_reg, wb_waddr_next;
   logic [N_REG-1:0]      wb_wdata_reg, wb_wdata_next;

   // Current contents of every entry, collected from the per-entry registers
   logic [N_REG-1:0] entry_q [N_ENTRY];

   // Read ports gathered into arrays so both share one generate body
   logic [N_REG_ADDR-1:0] rd_addr [N_PORT];
   logic                  rd_ren  [N_PORT];
   logic [N_REG-1:0]      rd_data [N_PORT];

   // Stall or flush replaces the incoming write with a bubble
   always_comb begin
      wb_wen_next   = i_wb_wen;
      wb_waddr_next = i_wb_waddr;
      wb_wdata_next = i_wb_wdata;
      if (i_stall || i_flush) begin
         wb_wen_next   = 1'b0;
         wb_waddr_next = '0;
         wb_wdata_next = '0;
      end
   end

   // Latch register; reset discards any pending write
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb_wen_reg   <= 1'b0;
         wb_waddr_reg <= '0;
         wb_wdata_reg <= '0;
      end else begin
         wb_wen_reg   <= wb_wen_next;
         wb_waddr_reg <= wb_waddr_next;
         wb_wdata_reg <= wb_wdata_next;
      end
   end

   assign o_wb_busy = wb_wen_reg;

   // One register per entry; entry 0 is hard-wired to zero so writes to it
   // vanish without any special-case logic in the write path.
   generate
      for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            assign entry_q[gi] = '0;
         end else begin : g_word
            logic [N_REG-1:0] word_reg;

            // Commit the latched write when it targets this entry
            always_ff @(posedge i_clk) begin
               if (i_rst) begin
                  word_reg <= '0;
               end else if (wb_wen_reg && (wb_waddr_reg == N_REG_ADDR'(gi))) begin
                  word_reg <= wb_wdata_reg;
               end
            end

            assign entry_q[gi] = word_reg;
         end
      end
   endgenerate

   assign rd_addr[0]   = i_reg_0_addr;
   assign rd_ren[0]    = i_reg_0_ren;
   assign rd_addr[1]   = i_reg_1_addr;
   assign rd_ren[1]    = i_reg_1_ren;
   assign o_reg_0_data = rd_data[0];
   assign o_reg_1_data = rd_data[1];

   generate
      for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
         // Priority: reset, disabled, r0, pending-write bypass, array
         always_comb begin
            rd_data[gi] = '0;
            if (i_rst || !rd_ren[gi] || (rd_addr[gi] == '0)) begin
               rd_data[gi] = '0;
            end else if (wb_wen_reg && (wb_waddr_reg == rd_addr[gi])) begin
               rd_data[gi] = wb_wdata_reg;
            end else begin
               rd_data[gi] = entry_q[rd_addr[gi]];
            end
         end
      end
   endgenerate

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter N_REG, default 32: register data width in bits.
REQ-002 Parameter N_REG_ADDR, default 5: register address width; the array holds 2**N_REG_ADDR entries.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_wb_wen  input  1  write-back request from the memory stage.
REQ-006 i_wb_waddr  input  N_REG_ADDR  write-back destination register.
REQ-007 i_wb_wdata  input  N_REG  write-back data.
REQ-008 i_stall  input  1  pipeline stall; forces a bubble into the write-back latch.
REQ-009 i_flush  input  1  pipeline flush; forces a bubble into the write-back latch.
REQ-010 i_reg_0_addr  input  N_REG_ADDR  read port 0 address from decode.
REQ-011 i_reg_0_ren  input  1  read port 0 enable.
REQ-012 i_reg_1_addr  input  N_REG_ADDR  read port 1 address from decode.
REQ-013 i_reg_1_ren  input  1  read port 1 enable.
REQ-014 o_reg_0_data  output  N_REG  read port 0 data (combinational).
REQ-015 o_reg_1_data  output  N_REG  read port 1 data (combinational).
REQ-016 o_wb_busy  output  1  write-back latch holds a valid pending write.

Function
REQ-017 The write-back latch (wb_wen, wb_waddr, wb_wdata) SHALL capture the i_wb_* inputs on every rising edge when i_stall=0 and i_flush=0.
REQ-018 When i_stall=1 or i_flush=1 (either or both), the latch SHALL load a bubble: wen=0, waddr=0, wdata=0. The i_wb_* inputs are discarded.
REQ-019 When latched wen=1 and waddr!=0, the array entry at waddr SHALL take wdata on the next rising edge.
- Total latency from i_wb_* to the array is 2 edges.
REQ-020 A latched write to address 0 SHALL be dropped. Entry 0 SHALL always read as 0.
REQ-021 o_wb_busy SHALL equal the latched wen, including writes to address 0.
REQ-022 Read port 0 data SHALL be selected in this priority order:
- i_rst=1 -> 0
- i_reg_0_ren=0 -> 0
- addr=0 -> 0
- latched wen=1 and latched waddr==addr -> latched wdata (bypass)
- otherwise -> array[addr]
REQ-023 Read port 1 SHALL use the same rules as REQ-022 with its own address and enable.
REQ-024 Both ports SHALL be able to read the same address in the same cycle, each producing the same value.
REQ-025 Only the write-back latch SHALL be bypassed. A value on i_wb_* in the current cycle is not visible on any read port.
REQ-026 There SHALL be exactly one write per cycle. A new capture and an array update in the same edge SHALL both occur, in pipeline order.

Reset
REQ-027 On a rising edge with i_rst=1:
- all array entries SHALL become 0;
- the latch SHALL become a bubble;
- o_wb_busy SHALL read 0 from the next cycle.
REQ-028 While i_rst=1, o_reg_0_data and o_reg_1_data SHALL read 0.
REQ-029 A write pending in the latch when reset asserts SHALL be lost and never reach the array.
REQ-030 i_rst SHALL take priority over i_stall, i_flush and i_wb_*.

Verification
REQ-031 Basic write/read: reset, then present i_wb_wen=1, waddr=5, wdata=0x12345678 for one cycle.
- Next cycle: port 0 addr 5, ren 1 -> 0x12345678 via bypass, o_wb_busy=1.
- Following cycle: 0x12345678 from the array, o_wb_busy=0.
REQ-032 Register zero: write 0xFFFFFFFF to address 0, then read address 0 on both ports for 3 cycles -> 0 every cycle.
REQ-033 Read enables: after 0xA5A5A5A5 has settled in r7, set both ren=0 with addr=7 -> both outputs 0. Set ren=1 -> both outputs 0xA5A5A5A5.
REQ-034 Stall/flush: present a write of 0xDEADBEEF to r3 with i_stall=1 for that cycle, then 0 thereafter.
- o_wb_busy stays 0 and r3 reads 0.
- Repeat with i_flush=1 -> same result.
REQ-035 Back-to-back to the same register: write r9=1 in cycle N and r9=2 in cycle N+1.
- Cycle N+1: r9 reads 1.
- Cycle N+2 onward: r9 reads 2.
REQ-036 Reset mid-operation: with a write of 0x55 to r4 latched (o_wb_busy=1), assert i_rst for one cycle.
- o_wb_busy=0 after reset.
- r4 reads 0, and every previously written register reads 0.
